// File: rtl/decode_pipe_pkg.sv
// Shared definitions for the decode pipeline:
// opcodes, instruction field layouts, helpers.
package decode_pipe_pkg;

    localparam int INSTR_W = 32;
    localparam int OP_W    = 6;

    typedef enum logic [OP_W-1:0] {
        OP_RTYPE = 6'h00,
        OP_J     = 6'h02,
        OP_BEQ   = 6'h04,
        OP_ADDI  = 6'h08,
        OP_LW    = 6'h23,
        OP_SW    = 6'h2B
    } op_code_e;

    typedef struct packed {
        logic [5:0] op;
        logic [4:0] rs;
        logic [4:0] rt;
        logic [4:0] rd;
        logic [4:0] shamt;
        logic [5:0] funct;
    } rtype_t;

    typedef struct packed {
        logic [5:0]  op;
        logic [4:0]  rs;
        logic [4:0]  rt;
        logic [15:0] imm;
    } itype_t;

    typedef struct packed {
        logic [5:0]  op;
        logic [25:0] target;
    } jtype_t;

    function automatic logic is_legal(logic [OP_W-1:0] op);
        return op == OP_RTYPE || op == OP_J   ||
               op == OP_BEQ   || op == OP_ADDI ||
               op == OP_LW    || op == OP_SW;
    endfunction

endpackage

// File: rtl/decode_pipe_if.sv
// Upstream, write-back and downstream signals
// of the decode stage.
interface decode_pipe_if #(
    parameter int XLEN  = 32,
    parameter int NREGS = 32
);
    localparam int RA = $clog2(NREGS);

    logic            in_valid;
    logic            in_ready;
    logic [31:0]     in_instr;
    logic            flush;
    logic            wb_valid;
    logic [RA-1:0]   wb_addr;
    logic [XLEN-1:0] wb_data;
    logic            out_valid;
    logic            out_ready;
    logic [5:0]      out_op;
    logic [XLEN-1:0] out_rs_val;
    logic [XLEN-1:0] out_rt_val;
    logic [XLEN-1:0] out_imm;
    logic [RA-1:0]   out_rd;
    logic            out_write;
    logic            out_illegal;

    modport master (
        output in_valid, in_instr, flush,
        output wb_valid, wb_addr, wb_data,
        output out_ready,
        input  in_ready, out_valid, out_op,
        input  out_rs_val, out_rt_val, out_imm,
        input  out_rd, out_write, out_illegal
    );

    modport slave (
        input  in_valid, in_instr, flush,
        input  wb_valid, wb_addr, wb_data,
        input  out_ready,
        output in_ready, out_valid, out_op,
        output out_rs_val, out_rt_val, out_imm,
        output out_rd, out_write, out_illegal
    );

endinterface

// File: rtl/decode_pipe_regfile_bp.sv
// Two-read one-write register file, r0 hardwired
// to zero, write-first bypass on both read ports.
module regfile_bp #(
    parameter int XLEN  = 32,
    parameter int NREGS = 32,
    localparam int RA   = $clog2(NREGS)
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            we,
    input  logic [RA-1:0]   wa,
    input  logic [XLEN-1:0] wd,
    input  logic [RA-1:0]   ra_a,
    input  logic [RA-1:0]   ra_b,
    output logic [XLEN-1:0] rd_a,
    output logic [XLEN-1:0] rd_b
);

    logic [XLEN-1:0] mem_q [NREGS];
    logic [XLEN-1:0] mem_d [NREGS];

    always_comb begin
        mem_d = mem_q;
        if (we && wa != '0) mem_d[wa] = wd;
    end

    always_ff @(posedge clk) begin
        if (reset) mem_q <= '{default: '0};
        else       mem_q <= mem_d;
    end

    always_comb begin
        rd_a = mem_q[ra_a];
        if (we && wa == ra_a) rd_a = wd;
        if (ra_a == '0)       rd_a = '0;
        rd_b = mem_q[ra_b];
        if (we && wa == ra_b) rd_b = wd;
        if (ra_b == '0)       rd_b = '0;
    end

endmodule

// File: rtl/decode_pipe.sv
// Decode stage: field decode, operand read,
// scoreboard interlock and one output register.
import decode_pipe_pkg::*;

module decode_pipe #(
    parameter int XLEN  = 32,
    parameter int NREGS = 32
) (
    input logic          clk,
    input logic          reset,
    decode_pipe_if.slave bus
);

    localparam int RA = $clog2(NREGS);

    rtype_t ri;
    itype_t it;
    jtype_t jt;
    logic [OP_W-1:0] op;
    logic unused_flds;

    assign ri = rtype_t'(bus.in_instr);
    assign it = itype_t'(bus.in_instr);
    assign jt = jtype_t'(bus.in_instr);
    assign op = ri.op;
    assign unused_flds = ^{ri.shamt, ri.funct,
                           it.op, it.rs, it.rt, jt.op};

    logic            use_rs, use_rt, wr, illegal;
    logic [RA-1:0]   rs_a, rt_a, dst_a;
    logic [XLEN-1:0] imm, rs_val, rt_val;

    always_comb begin
        use_rs  = 1'b0;
        use_rt  = 1'b0;
        wr      = 1'b0;
        illegal = 1'b0;
        dst_a   = '0;
        imm     = XLEN'($signed(it.imm));
        unique case (1'b1)
            op == OP_RTYPE: begin
                use_rs = 1'b1;
                use_rt = 1'b1;
                dst_a  = ri.rd[RA-1:0];
                wr     = 1'b1;
            end
            op == OP_ADDI, op == OP_LW: begin
                use_rs = 1'b1;
                dst_a  = ri.rt[RA-1:0];
                wr     = 1'b1;
            end
            op == OP_BEQ, op == OP_SW: begin
                use_rs = 1'b1;
                use_rt = 1'b1;
            end
            op == OP_J: imm = XLEN'(jt.target);
            default: illegal = !is_legal(op);
        endcase
        // writes to r0 are dropped, so never track them
        if (dst_a == '0) wr = 1'b0;
        if (!wr)         dst_a = '0;
        rs_a = use_rs ? ri.rs[RA-1:0] : '0;
        rt_a = use_rt ? ri.rt[RA-1:0] : '0;
    end

    regfile_bp #(.XLEN(XLEN), .NREGS(NREGS)) u_rf (
        .clk  (clk),
        .reset(reset),
        .we   (bus.wb_valid),
        .wa   (bus.wb_addr),
        .wd   (bus.wb_data),
        .ra_a (rs_a),
        .ra_b (rt_a),
        .rd_a (rs_val),
        .rd_b (rt_val)
    );

    logic [NREGS-1:0] busy_q, busy_d;
    logic            out_valid_q, out_valid_d;
    logic [5:0]      out_op_q, out_op_d;
    logic [XLEN-1:0] out_rs_q, out_rs_d;
    logic [XLEN-1:0] out_rt_q, out_rt_d;
    logic [XLEN-1:0] out_imm_q, out_imm_d;
    logic [RA-1:0]   out_rd_q, out_rd_d;
    logic            out_write_q, out_write_d;
    logic            out_ill_q, out_ill_d;

    logic haz_rs, haz_rt, hazard, fire, load, in_ready;

    always_comb begin
        haz_rs = busy_q[rs_a] &&
                 !(bus.wb_valid && bus.wb_addr == rs_a);
        haz_rs = haz_rs || (out_valid_q && out_write_q &&
                            out_rd_q == rs_a);
        haz_rt = busy_q[rt_a] &&
                 !(bus.wb_valid && bus.wb_addr == rt_a);
        haz_rt = haz_rt || (out_valid_q && out_write_q &&
                            out_rd_q == rt_a);
        hazard = haz_rs || haz_rt;
    end

    assign in_ready = (!out_valid_q || bus.out_ready) &&
                      !hazard && !bus.flush && !reset;
    assign load = bus.in_valid && in_ready;
    assign fire = out_valid_q && bus.out_ready && !bus.flush;

    always_comb begin
        busy_d = busy_q;
        if (bus.wb_valid)         busy_d[bus.wb_addr] = 1'b0;
        if (fire && out_write_q)  busy_d[out_rd_q] = 1'b1;

        out_valid_d = out_valid_q;
        if (fire)     out_valid_d = 1'b0;
        if (load)     out_valid_d = 1'b1;
        if (bus.flush) out_valid_d = 1'b0;

        out_op_d    = out_op_q;
        out_rs_d    = out_rs_q;
        out_rt_d    = out_rt_q;
        out_imm_d   = out_imm_q;
        out_rd_d    = out_rd_q;
        out_write_d = out_write_q;
        out_ill_d   = out_ill_q;
        if (load) begin
            out_op_d    = op;
            out_rs_d    = rs_val;
            out_rt_d    = rt_val;
            out_imm_d   = imm;
            out_rd_d    = dst_a;
            out_write_d = wr;
            out_ill_d   = illegal;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            busy_q      <= '0;
            out_valid_q <= 1'b0;
            out_op_q    <= '0;
            out_rs_q    <= '0;
            out_rt_q    <= '0;
            out_imm_q   <= '0;
            out_rd_q    <= '0;
            out_write_q <= 1'b0;
            out_ill_q   <= 1'b0;
        end else begin
            busy_q      <= busy_d;
            out_valid_q <= out_valid_d;
            out_op_q    <= out_op_d;
            out_rs_q    <= out_rs_d;
            out_rt_q    <= out_rt_d;
            out_imm_q   <= out_imm_d;
            out_rd_q    <= out_rd_d;
            out_write_q <= out_write_d;
            out_ill_q   <= out_ill_d;
        end
    end

    assign bus.in_ready    = in_ready;
    assign bus.out_valid   = out_valid_q;
    assign bus.out_op      = out_op_q;
    assign bus.out_rs_val  = out_rs_q;
    assign bus.out_rt_val  = out_rt_q;
    assign bus.out_imm     = out_imm_q;
    assign bus.out_rd      = out_rd_q;
    assign bus.out_write   = out_write_q;
    assign bus.out_illegal = out_ill_q;

endmodule
